iter_int_mul_param: RTL
=======================

ITER_INT_MUL_PARAM -- requirements
Module: iter_int_mul_param

Interface
REQ-001 Parameter A_W, default 8: multiplier (operand A) width, >= 2.
REQ-002 Parameter B_W, default 32: multiplicand (operand B) width, >= 2.
REQ-003 Derived P_W = A_W+B_W: product width, not overridable.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_val  input  1  request operands valid.
REQ-007 req_rdy  output  1  block can accept a request.
REQ-008 req_a  input  A_W  operand A.
REQ-009 req_b  input  B_W  operand B.
REQ-010 req_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
REQ-011 resp_val  output  1  product valid.
REQ-012 resp_rdy  input  1  consumer accepts the product.
REQ-013 resp_p  output  P_W  product.
REQ-014 busy  output  1  high in CALC or DONE.

Function
REQ-015 Three states: IDLE, CALC, DONE. Moore outputs: req_rdy = (IDLE), resp_val = (DONE), busy = (CALC or DONE).
REQ-016 IDLE->CALC on the edge where req_val && req_rdy. Operands and mode are captured on that edge. No other transition out of IDLE.
REQ-017 On capture in signed mode: A and B are replaced by their magnitudes, and neg = sign(A) xor sign(B) is stored. In unsigned mode neg = 0.
REQ-018 The magnitude of the most-negative value (-2^(W-1)) is held as the unsigned value 2^(W-1) with no overflow. Registers are A_W and B_W bits wide, treated as unsigned.
REQ-019 Each CALC cycle: if a_reg[0]=1, acc += b_ext (P_W bits); then a_reg >>= 1 (logical) and b_ext <<= 1. b_ext is the zero-extended B.
REQ-020 Early termination: leave CALC for DONE after the cycle in which the shifted a_reg becomes 0. The CALC dwell is max(1, msb_index(|A|)+1) cycles, never more than A_W.
REQ-021 Entering DONE: resp_p = neg ? (~acc + 1) : acc, modulo 2^P_W. A zero product has a result of 0 regardless of neg.
REQ-022 DONE->IDLE on the edge where resp_val && resp_rdy. While resp_rdy = 0, resp_p and resp_val hold stable indefinitely.
REQ-023 No overlap: a new request is not accepted in the same cycle as a response handshake. req_rdy rises the cycle after.
REQ-024 req_val, req_a, req_b and req_signed are ignored outside IDLE. Changing them mid-operation does not affect the result.
REQ-025 resp_p is registered and changes only on DONE entry or reset.
REQ-026 Arithmetic is exact: P_W bits hold every unsigned or signed product with no truncation.

Reset
REQ-027 Asserting reset forces state = IDLE, req_rdy = 1, resp_val = 0, busy = 0, resp_p = 0, and clears acc, a_reg, b_ext and neg, asynchronously in any state.
REQ-028 Reset mid-CALC or mid-DONE discards the operation with no response. The first edge after deassertion may accept a new request.
REQ-029 Outputs are defined from the first cycle of reset. There are no X values on req_rdy, resp_val or busy.

Verification (A_W=8, B_W=32)
REQ-030 Unsigned, A=5, B=7, resp_rdy=1 -> exactly 3 CALC cycles, then resp_val=1 with resp_p=0x0000000023, and req_rdy=1 the next cycle.
REQ-031 Unsigned, A=0xFF, B=0xFFFFFFFF -> 8 CALC cycles, resp_p=0xFEFFFFFF01.
REQ-032 Signed, A=0xFD (-3), B=100 -> 2 CALC cycles, resp_p=0xFFFFFFFED4 (-300). Signed A=0x80 (-128), B=0xFFFFFFFF (-1) -> 8 CALC cycles, resp_p=0x0000000080.
REQ-033 A=0, any B, either mode -> 1 CALC cycle, resp_p=0. Hold resp_rdy=0 for 5 cycles in DONE, with req_val=1 and new operands toggling -> resp_p and resp_val stable and req_rdy=0 throughout; the result is accepted on the first resp_rdy=1 edge.
REQ-034 Start A=0xFF, B=3; assert reset in the 4th CALC cycle -> outputs immediately at reset values and no resp_val. After release, A=2, B=9 -> resp_p=0x0000000012, with no residue from the aborted operation.
REQ-035 Back-to-back: 10 random requests with req_val held high and random resp_rdy stalls -> every product matches the reference model in order. One accept per response. CALC dwell always equals REQ-020.

Source files
------------

// File: rtl/iter_int_mul_param.sv
// Iterative shift-and-add integer multiplier, unsigned or two's-complement.
// One multiplier bit per CALC cycle, finishing as soon as the remaining multiplier bits are zero.
module iter_int_mul_param #(
    parameter int A_W = 8,
    parameter int B_W = 32,
    localparam int P_W = A_W + B_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_val,
    output logic           req_rdy,
    input  logic [A_W-1:0] req_a,
    input  logic [B_W-1:0] req_b,
    input  logic           req_signed,
    output logic           resp_val,
    input  logic           resp_rdy,
    output logic [P_W-1:0] resp_p,
    output logic           busy
);

    // state | meaning
    // IDLE  | waiting for a request; operands captured on accept
    // CALC  | one shift-and-add step per cycle on the operand magnitudes
    // DONE  | product held on resp_p until the consumer accepts it
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [A_W-1:0] a_reg;
    logic [P_W-1:0] b_ext;
    logic [P_W-1:0] acc;
    logic           neg;

    logic [A_W-1:0] a_mag;
    logic [B_W-1:0] b_mag;
    logic [P_W-1:0] acc_sum;
    logic [A_W-1:0] a_shift;
    logic           calc_last;

    // Magnitudes stay unsigned, so -2^(W-1) maps to 2^(W-1) without overflow.
    always_comb begin
        a_mag     = (req_signed && req_a[A_W-1]) ? (~req_a + A_W'(1)) : req_a;
        b_mag     = (req_signed && req_b[B_W-1]) ? (~req_b + B_W'(1)) : req_b;
        acc_sum   = a_reg[0] ? (acc + b_ext) : acc;
        a_shift   = a_reg >> 1;
        calc_last = (a_shift == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_rdy    = 1'b0;
        resp_val   = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (calc_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                resp_val = 1'b1;
                if (resp_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg  <= '0;
            b_ext  <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            resp_p <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_val) begin
                        a_reg <= a_mag;
                        b_ext <= {{A_W{1'b0}}, b_mag};
                        acc   <= '0;
                        neg   <= req_signed & (req_a[A_W-1] ^ req_b[B_W-1]);
                    end
                end
                CALC: begin
                    acc   <= acc_sum;
                    a_reg <= a_shift;
                    b_ext <= b_ext << 1;
                    // Negating a zero accumulator yields zero, so a zero product never comes out negative.
                    if (calc_last) begin
                        resp_p <= neg ? (~acc_sum + P_W'(1)) : acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
